// File: rtl/icetap_capture_ctrl_if.sv
// icetap readout stream toward the host link.
// One beat per accepted valid/ready handshake.
interface icetap_capture_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  out_valid;
    logic                  out_last;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_ready;

    modport master (
        output out_valid,
        output out_last,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_last,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/icetap_capture_ctrl.sv
// icetap capture/readout sequencer: circular pre/post-trigger capture
// into the sample memory, then oldest-first readout over valid/ready.
module icetap_capture_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] pre_trig_cnt,
    input  logic [ADDR_WIDTH-1:0] post_trig_cnt,
    input  logic                  sample_valid,
    input  logic [DATA_WIDTH-1:0] sample_data,
    input  logic                  trigger,
    output logic                  mem_wr_ena,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic                  mem_rd_ena,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    input  logic                  rd_start,
    icetap_capture_ctrl_if.master out_if,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] trig_addr,
    output logic [ADDR_WIDTH:0]   num_samples
);
    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_ARMED, S_POST, S_DONE, S_READ
    } state_t;

    localparam logic [ADDR_WIDTH:0] W_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH:0]   r_num;
    logic [ADDR_WIDTH-1:0] r_pre_lat;
    logic [ADDR_WIDTH-1:0] r_post_lat;
    logic [ADDR_WIDTH-1:0] r_pre_cnt;
    logic [ADDR_WIDTH-1:0] r_post_rem;
    logic [ADDR_WIDTH-1:0] r_trig_addr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_rd_rem;
    logic                  r_out_valid;
    logic                  r_wr_ena;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;

    logic                  w_capturing;
    logic                  w_cap;
    logic                  w_rd_ena;
    logic                  w_last_acc;
    logic [ADDR_WIDTH-1:0] w_pre_nxt;
    logic [ADDR_WIDTH-1:0] w_oldest;

    assign w_capturing = (r_state == S_PRE) || (r_state == S_ARMED) ||
                         (r_state == S_POST);
    assign w_cap       = sample_valid & w_capturing;
    assign w_rd_ena    = (r_state == S_READ) && (r_rd_rem != '0) &&
                         (!r_out_valid || out_if.out_ready);
    assign w_last_acc  = (r_state == S_READ) && r_out_valid &&
                         out_if.out_ready && (r_rd_rem == '0);
    assign w_pre_nxt   = r_pre_cnt + 1'b1;
    // A full buffer (num=DEPTH) wraps to oldest == wr_ptr.
    assign w_oldest    = r_wr_ptr - r_num[ADDR_WIDTH-1:0];

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_state     <= S_IDLE;
            r_wr_ptr    <= '0;
            r_num       <= '0;
            r_pre_lat   <= '0;
            r_post_lat  <= '0;
            r_pre_cnt   <= '0;
            r_post_rem  <= '0;
            r_trig_addr <= '0;
            r_rd_ptr    <= '0;
            r_rd_rem    <= '0;
            r_out_valid <= 1'b0;
            r_wr_ena    <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
        end else begin
            r_wr_ena <= 1'b0;
            if (w_cap) begin
                r_wr_ena  <= 1'b1;
                r_wr_addr <= r_wr_ptr;
                r_wr_data <= sample_data;
                r_wr_ptr  <= r_wr_ptr + 1'b1;
                if (r_num != W_DEPTH) r_num <= r_num + 1'b1;
            end
            if (w_rd_ena) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_rd_rem <= r_rd_rem - 1'b1;
            end
            r_out_valid <= w_rd_ena | (r_out_valid & ~out_if.out_ready);
            if (abort) begin
                r_state     <= S_IDLE;
                r_wr_ena    <= 1'b0;
                r_out_valid <= 1'b0;
            end else begin
                unique case (r_state)
                    S_IDLE, S_DONE: begin
                        if (start) begin
                            r_wr_ptr   <= '0;
                            r_num      <= '0;
                            r_pre_lat  <= pre_trig_cnt;
                            r_post_lat <= post_trig_cnt;
                            r_pre_cnt  <= '0;
                            r_state    <= (pre_trig_cnt == '0) ? S_ARMED : S_PRE;
                        end else if (r_state == S_DONE && rd_start) begin
                            r_rd_ptr <= w_oldest;
                            r_rd_rem <= r_num;
                            r_state  <= S_READ;
                        end
                    end
                    S_PRE: begin
                        if (sample_valid) begin
                            r_pre_cnt <= w_pre_nxt;
                            if (w_pre_nxt == r_pre_lat) r_state <= S_ARMED;
                        end
                    end
                    S_ARMED: begin
                        if (sample_valid && trigger) begin
                            r_trig_addr <= r_wr_ptr;
                            r_post_rem  <= r_post_lat;
                            r_state     <= (r_post_lat == '0) ? S_DONE : S_POST;
                        end
                    end
                    S_POST: begin
                        if (sample_valid) begin
                            r_post_rem <= r_post_rem - 1'b1;
                            if (r_post_rem == ADDR_WIDTH'(1)) r_state <= S_DONE;
                        end
                    end
                    S_READ: begin
                        if (w_last_acc) r_state <= S_DONE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign mem_wr_ena       = r_wr_ena;
    assign mem_wr_addr      = r_wr_addr;
    assign mem_wr_data      = r_wr_data;
    assign mem_rd_ena       = w_rd_ena;
    assign mem_rd_addr      = r_rd_ptr;
    assign out_if.out_valid = r_out_valid;
    assign out_if.out_last  = r_out_valid && (r_rd_rem == '0);
    assign out_if.out_data  = mem_rd_data;
    assign busy             = w_capturing;
    assign done             = (r_state == S_DONE);
    assign trig_addr        = r_trig_addr;
    assign num_samples      = r_num;
endmodule

// File: doc/icetap_capture_ctrl.md
# icetap_capture_ctrl

Capture and readout sequencer for the icetap logic analyzer sample memory. It writes the sample stream into the memory's write port as a circular buffer. It holds off the trigger until a programmed number of pre-trigger samples has been stored, then records a programmed number of post-trigger samples and stops. It then streams the captured window, oldest sample first, out of the memory's read port through a valid/ready interface toward the host link.

## Interface
- ADDR_WIDTH, 8, sample memory address width; DEPTH = 2**ADDR_WIDTH entries are used.
- DATA_WIDTH, 8, sample width.

- clk  in  1  single clock for capture, memory and readout; memory wr_clk and rd_clk both tie to clk.
- reset_  in  1  asynchronous, active-low reset.
- start  in  1  pulse; arms a new capture; honoured only in IDLE or DONE.
- abort  in  1  pulse; returns to IDLE from any state; takes priority over start and rd_start.
- pre_trig_cnt  in  ADDR_WIDTH  samples required before the trigger is honoured; latched on start.
- post_trig_cnt  in  ADDR_WIDTH  samples stored after the trigger sample; latched on start.
- sample_valid  in  1  sample_data is valid this cycle.
- sample_data  in  DATA_WIDTH  captured signals.
- trigger  in  1  trigger condition; qualified by sample_valid.
- mem_wr_ena, mem_wr_addr, mem_wr_data  out  1/ADDR_WIDTH/DATA_WIDTH  memory write port; all registered.
- mem_rd_ena, mem_rd_addr  out  1/ADDR_WIDTH  memory read port; combinational from state.
- mem_rd_data  in  DATA_WIDTH  memory read data; 1-cycle latency; holds its value while mem_rd_ena=0.
- rd_start  in  1  pulse; starts readout; honoured only in DONE.
- out_valid, out_last  out  1  readout beat valid / final beat.
- out_data  out  DATA_WIDTH  driven directly by mem_rd_data.
- out_ready  in  1  downstream accepts the beat.
- busy  out  1  state is PRE, ARMED or POST.
- done  out  1  state is DONE.
- trig_addr  out  ADDR_WIDTH  memory address of the trigger sample.
- num_samples  out  ADDR_WIDTH+1  valid samples in the buffer; range 1..DEPTH in DONE.

## Operation
- States: IDLE, PRE, ARMED, POST, DONE, READ.
- IDLE/DONE + start:
  - wr_ptr=0, num_samples=0.
  - Latch pre_trig_cnt and post_trig_cnt.
  - Go to PRE, or directly to ARMED when pre_trig_cnt=0.
- Every sample_valid in PRE, ARMED or POST:
  - Register a write (mem_wr_addr=wr_ptr, mem_wr_data=sample_data).
  - wr_ptr+1, wrapping mod DEPTH.
  - num_samples+1, saturating at DEPTH.
- PRE:
  - trigger is ignored.
  - After the sample that brings the pre count to pre_trig_cnt, go to ARMED.
- ARMED:
  - On sample_valid & trigger, write that sample and latch trig_addr=wr_ptr.
  - Load post counter with post_trig_cnt.
  - Go to POST, or directly to DONE when post_trig_cnt=0.
- POST:
  - Each sample_valid writes and decrements the post counter.
  - trigger is ignored.
  - The write that takes the counter to 0 moves the state to DONE.
- DONE:
  - No writes.
  - oldest = (wr_ptr - num_samples) mod DEPTH.
  - When pre+post+1 > DEPTH, the oldest pre-trigger samples have been overwritten; this is defined behaviour.
- DONE + rd_start:
  - rd_ptr=oldest, rd_remaining=num_samples.
  - Go to READ.
- READ:
  - mem_rd_ena = rd_remaining!=0 & (!out_valid | out_ready).
  - mem_rd_addr = rd_ptr.
  - Each issued read does rd_ptr+1 (wrapping) and rd_remaining-1.
  - out_valid next = mem_rd_ena | (out_valid & !out_ready).
  - out_last = out_valid & rd_remaining==0.
  - When the last beat is accepted, go to DONE; the buffer can be read again.
- abort:
  - Next state is IDLE.
  - mem_wr_ena and out_valid are 0 from the next cycle.
  - Buffer contents are left unchanged.
- start outside IDLE/DONE and rd_start outside DONE are ignored.

## Timing
- Reset values:
  - State IDLE; busy, done, mem_wr_ena, mem_rd_ena, out_valid, out_last all 0.
  - wr_ptr, rd_ptr, trig_addr, num_samples, mem_wr_addr, mem_wr_data all 0.
- Sample accepted in cycle T appears on the memory write port in T+1 and is stored at the end of T+1.
- A state change caused by a sample in cycle T is visible in T+1.
- done rises the cycle after the final post-trigger sample; the last write completes in that same cycle.
- rd_start in cycle D: READ from D+1; first mem_rd_ena in D+1; first out_valid in D+2.
- Under continuous out_ready, one beat per cycle with no gaps. num_samples=N takes N+1 cycles from the first read to the last accept.
- Backpressure: out_data and out_valid stay stable while out_valid & !out_ready.

## Test plan
- DEPTH=256, pre=4, post=3; samples 0,1,2,…; trigger on sample value 10 -> trigger ignored during PRE, trig_addr=10, num_samples=14, readout emits 0..13, out_last on 13.
- pre=0, post=0; trigger on the first sample (value 0x55) -> DONE after 1 sample; readout is a single beat 0x55 with out_last=1.
- pre=8, post=4; trigger after 300 samples (ARMED writes wrap) -> num_samples=256; first beat is the value at address (wr_ptr-256) mod 256; 256 beats in ascending capture order.
- Readout with out_ready toggling 1,0,0,1 -> no beat lost or duplicated; out_data held constant while stalled.
- abort during POST and again mid-READ -> IDLE next cycle, out_valid=0, no further mem_wr_ena; a following start captures normally.
- Async reset asserted mid-capture -> all outputs at reset values immediately; start pulse during POST and rd_start outside DONE -> ignored.
